mem_port_responder: RTL and testbench
=====================================

# mem_port_responder

Responder end of the processor's four-port memory interface. Arbitrates up to four requesters (instruction fetch, data, reserve, spare) onto a single 128×8 synchronous memory array, performs one read or write per granted request and returns data with a one-cycle acknowledge pulse. It sits directly below the processor; every instruction fetch and load/store passes through it.

## Interface

Parameters:
- ADDR_W, 7, address width (128 bytes)
- DATA_W, 8, data width
- NPORTS, 4, number of requester ports (fixed; other values unsupported)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  4  per-port request, bit i = port i; held high until ack[i]
- we  in  4  per-port write enable, sampled with req
- addr  in  28  per-port address, port i at [7i+6:7i]
- wdata  in  32  per-port write data, port i at [8i+7:8i]
- rdata  out  32  per-port read data, port i at [8i+7:8i]
- ack  out  4  per-port one-cycle completion pulse
- busy  out  1  high while a transaction is in flight
- disp  out  32  display registers DISP0..DISP3 (present only with MEM_DISPLAY_EN)

## Operation

- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req bit is high, pick a winner round-robin starting at rr_ptr; latch port index, we, addr, wdata; go to ACCESS. Otherwise stay.
- ACCESS: write: mem[addr] <= wdata; read: capture mem[addr] into an internal data register. Go to DONE.
- DONE: assert ack[winner] for exactly one cycle; for reads, drive rdata[winner] with the captured byte (other ports' rdata unchanged); for writes, rdata[winner] = written byte. rr_ptr <= winner+1 mod 4. Return to IDLE.
- Port rdata slices hold their last value until that port's next completion.
- busy = (state != IDLE).
- Requests are sampled only in IDLE; req/addr changes during ACCESS/DONE are ignored for the current transaction.
- A requester whose req stays high in the cycle after ack is treated as a new request (re-arbitrated normally).
- Address arithmetic: 7-bit, no wrap logic needed; all 128 locations valid.
- Memory contents are not reset and power up undefined.

## Timing

- Reset values: state IDLE, rr_ptr 0, ack 0, rdata 0, busy 0, disp 0.
- Latency: req seen high at IDLE edge N → ack at cycle N+2 (rdata valid in same cycle as ack).
- Throughput: one transaction per 3 cycles; with all four ports requesting continuously, each port completes once per 12 cycles.
- Simultaneous requests: round-robin; the port at rr_ptr has highest priority, then rr_ptr+1, etc.
- Reset asserted mid-transaction: FSM returns to IDLE, no ack issued, a pending write in ACCESS is not committed if reset arrives before that edge; requester must reissue.

## Configuration

- MEM_DISPLAY_EN defined: addresses 28..31 are also mirrored into disp[8k+7:8k] (k = addr-28) on every write committed in ACCESS; reads of those addresses still come from the array. disp resets to 0.
- MEM_DISPLAY_EN undefined: disp port and mirror registers do not exist; addresses 28..31 are ordinary memory.

## Structure

- Shared package (mem_pkg): ADDR_W, DATA_W, NPORTS, FSM state enum, DISP0..DISP3 address constants (28..31), port index constants (PORT_IR=0, PORT_DATA=1, PORT_RESERVE=2, PORT_AUX=3).
- One sub-module: rr_arbiter (4-bit req + pointer in, one-hot grant + index out, combinational).
- Memory array inferred in the top block.

## Test plan

- Write then read, port 1: write 0x5A to addr 0x10, then read 0x10 → ack[1] 2 cycles after each req, rdata[15:8]=0x5A.
- All four ports request reads from reset → grant order 0,1,2,3, acks 3 cycles apart, then port 0 again if still requesting.
- Port 2 and port 0 request together with rr_ptr=1 → port 2 served first, port 0 next.
- Reset asserted in ACCESS of a write of 0xFF to addr 5 → no ack, mem[5] unchanged, all outputs 0.
- With MEM_DISPLAY_EN: write 0x33 to addr 30 → disp[23:16]=0x33 after ACCESS edge; without macro, read of addr 30 returns 0x33 and no disp port exists.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the four-port memory responder.
//   ADDR_W/DATA_W/NPORTS  - array geometry and requester count
//   state_e               - responder FSM states
//   DISP0..DISP3          - byte addresses mirrored into the display registers
//   PORT_*                - requester port indices
package mem_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NPORTS = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [ADDR_W-1:0] DISP0 = 7'd28;
  localparam logic [ADDR_W-1:0] DISP1 = 7'd29;
  localparam logic [ADDR_W-1:0] DISP2 = 7'd30;
  localparam logic [ADDR_W-1:0] DISP3 = 7'd31;

  localparam logic [1:0] PORT_IR      = 2'd0;
  localparam logic [1:0] PORT_DATA    = 2'd1;
  localparam logic [1:0] PORT_RESERVE = 2'd2;
  localparam logic [1:0] PORT_AUX     = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter for four requesters.
//   req   - request vector, bit i = port i
//   ptr   - highest-priority port this round
//   grant - one-hot grant (all zero when no request)
//   idx   - binary index of the granted port (0 when no request)
module rr_arbiter
  import mem_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic [1:0]        ptr,
  output logic [NPORTS-1:0] grant,
  output logic [1:0]        idx
);

  logic       found;
  logic [1:0] cand;

  // Scan ptr, ptr+1, ... ; the 2-bit candidate wraps modulo 4 by itself.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      cand = ptr + k[1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_responder.sv
// mem_port_responder: arbitrates four requesters onto one 128x8 synchronous
// array; one read or write per grant, answered with a one-cycle ack pulse.
//   clk, reset     - clock, asynchronous active-high reset
//   req/we         - per-port request and write enable (4 bits)
//   addr/wdata     - per-port address (7 bits each) and write data (8 bits each)
//   rdata          - per-port read data, each slice holds until its next completion
//   ack            - per-port completion pulse
//   busy           - transaction in flight
//   disp           - display mirror of addresses 28..31 (only with MEM_DISPLAY_EN)
module mem_port_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W,
  parameter int unsigned NPORTS = mem_pkg::NPORTS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] wdata,
  output logic [NPORTS*DATA_W-1:0] rdata,
  output logic [NPORTS-1:0]        ack,
  output logic                     busy
`ifdef MEM_DISPLAY_EN
  ,
  output logic [4*DATA_W-1:0]      disp
`endif
);

  state_e              state_q, state_d;
  logic [1:0]          rr_q;
  logic [1:0]          win_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   data_q;
  logic [NPORTS*DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic [NPORTS-1:0]   grant;
  logic [1:0]          gidx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arbiter u_arb (
    .req   (req),
    .ptr   (rr_q),
    .grant (grant),
    .idx   (gidx)
  );

  always_comb begin
    sel_we    = |(we & grant);
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (gidx == p[1:0]) begin
        sel_addr  = addr[p*ADDR_W +: ADDR_W];
        sel_wdata = wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rdata is the held register with the winner's slice replaced during DONE,
  // so data appears in the ack cycle and is then retained by rdata_q.
  always_comb begin
    rdata_d = rdata_q;
    ack     = '0;
    if (state_q == DONE) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (win_q == p[1:0]) begin
          rdata_d[p*DATA_W +: DATA_W] = data_q;
          ack[p]                      = 1'b1;
        end
      end
    end
  end

  assign rdata = rdata_d;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (state_q == IDLE && (|req)) begin
        win_q   <= gidx;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state_q == DONE) rr_q <= win_q + 2'd1;
    end
  end

  // Array and capture register are not reset; the async reset forces
  // state_q to IDLE, which already blocks a pending ACCESS write.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS) begin
      if (we_q) begin
        mem_q[addr_q] <= wdata_q;
        data_q        <= wdata_q;
      end else begin
        data_q <= mem_q[addr_q];
      end
    end
  end

`ifdef MEM_DISPLAY_EN
  logic [4*DATA_W-1:0] disp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q <= '0;
    end else if (state_q == ACCESS && we_q) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (addr_q == DISP0 + k[ADDR_W-1:0]) disp_q[k*DATA_W +: DATA_W] <= wdata_q;
      end
    end
  end

  assign disp = disp_q;
`endif

endmodule

// File: tb/tb_mem_port_responder.sv
module tb_mem_port_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, we, ack;
  logic [27:0] addr;
  logic [31:0] wdata, rdata;
  logic        busy;
`ifdef MEM_DISPLAY_EN
  logic [31:0] disp;
`endif

  always #5 clk = ~clk;

  mem_port_responder dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .busy  (busy)
`ifdef MEM_DISPLAY_EN
    ,
    .disp  (disp)
`endif
  );

  typedef struct {
    int unsigned port;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    int unsigned port;
    logic        w;
    logic [6:0]  a;
    logic [7:0]  d;
  } vec_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc[4];
  int unsigned remaining[4];
  int unsigned last_ack;
  bit          have_last;
  logic [31:0] exp_rd;
  logic [7:0]  model[128];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int unsigned p, input logic w, input logic [6:0] a,
                       input logic [7:0] d, input int unsigned cnt, input bit push);
    logic [7:0] e;
    req[p]           = 1'b1;
    we[p]            = w;
    addr[p*7 +: 7]   = a;
    wdata[p*8 +: 8]  = d;
    remaining[p]     = cnt;
    start_cyc[p]     = cyc;
    if (push) begin
      e = w ? d : model[a];
      if (w) model[a] = d;
      sb.push_back('{port: p, data: e});
    end
  endtask

  task automatic service(input int unsigned budget, input bit chk_lat, input bit chk_gap);
    int unsigned n = 0;
    exp_t e;
    have_last = 1'b0;
    while ((req != 4'b0 || busy || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      cyc++;
      n++;
      if (ack != 4'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {28'b0, ack}, 32'h0);
        end else begin
          e = sb.pop_front();
          exp_rd[e.port*8 +: 8] = e.data;
          check("ack_port", {28'b0, ack}, 32'h1 << e.port);
          check("rdata", rdata, exp_rd);
          if (chk_lat) check("latency", cyc - start_cyc[e.port], 32'd2);
          if (chk_gap && have_last) check("ack_gap", cyc - last_ack, 32'd3);
          last_ack  = cyc;
          have_last = 1'b1;
        end
        for (int p = 0; p < 4; p++) begin
          if (ack[p] && remaining[p] > 0) begin
            remaining[p]--;
            if (remaining[p] == 0) req[p] = 1'b0;
          end
        end
      end
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d transactions outstanding, required 0", sb.size());
      req = 4'b0;
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, {28'b0, ack}, 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_busy"}, {31'b0, busy}, 32'h0);
`ifdef MEM_DISPLAY_EN
    check({tag, "_disp"}, disp, 32'h0);
`endif
  endtask

  vec_t tv[10];

  initial begin
    tv[0] = '{port: 1, w: 1'b1, a: 7'h10, d: 8'h5A};
    tv[1] = '{port: 1, w: 1'b0, a: 7'h10, d: 8'h00};
    tv[2] = '{port: 0, w: 1'b1, a: 7'h00, d: 8'h11};
    tv[3] = '{port: 2, w: 1'b1, a: 7'h7F, d: 8'hC3};
    tv[4] = '{port: 3, w: 1'b1, a: 7'h05, d: 8'h21};
    tv[5] = '{port: 0, w: 1'b0, a: 7'h7F, d: 8'h00};
    tv[6] = '{port: 3, w: 1'b0, a: 7'h00, d: 8'h00};
    tv[7] = '{port: 2, w: 1'b0, a: 7'h05, d: 8'h00};
    tv[8] = '{port: 0, w: 1'b1, a: 7'd30, d: 8'h33};
    tv[9] = '{port: 1, w: 1'b0, a: 7'd30, d: 8'h00};

    reset  = 1'b1;
    req    = '0;
    we     = '0;
    addr   = '0;
    wdata  = '0;
    exp_rd = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Single-port vectors: write/read mix checked through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(tv[i].port, tv[i].w, tv[i].a, tv[i].d, 1, 1'b1);
      service(20, 1'b1, 1'b0);
`ifdef MEM_DISPLAY_EN
      if (i == 8) begin
        check("disp_byte2", {24'b0, disp[23:16]}, 32'h33);
        check("disp_others", {disp[31:24], 8'h00, disp[15:0]}, 32'h0);
      end
`endif
    end

    // All four ports from reset: order 0,1,2,3 then port 0 again.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    exp_rd = '0;
    issue(0, 1'b0, 7'h10, 8'h00, 2, 1'b1);
    issue(1, 1'b0, 7'h00, 8'h00, 1, 1'b1);
    issue(2, 1'b0, 7'h7F, 8'h00, 1, 1'b1);
    issue(3, 1'b0, 7'h05, 8'h00, 1, 1'b1);
    sb.push_back('{port: 0, data: model[7'h10]});
    service(60, 1'b0, 1'b1);

    // rr_ptr is now 1: port 2 beats port 0.
    @(negedge clk);
    issue(2, 1'b0, 7'h10, 8'h00, 1, 1'b1);
    issue(0, 1'b0, 7'h7F, 8'h00, 1, 1'b1);
    service(30, 1'b0, 1'b1);

    // Reset during ACCESS of a write: nothing committed, no ack.
    @(negedge clk);
    issue(1, 1'b1, 7'h05, 8'hFF, 1, 1'b0);
    @(posedge clk);
    #2;
    check("busy_in_access", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    req = '0;
    check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    reset  = 1'b0;
    exp_rd = '0;
    @(negedge clk);
    issue(3, 1'b0, 7'h05, 8'h00, 1, 1'b1);
    service(20, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
